// File: rtl/button_conditioner.sv
// Synchronises and debounces two push buttons and two slide switches in front of the
// shift/load FSM: a clean reset level, a one-shot execute pulse and a frozen switch value.
`timescale 1ns/1ps
module button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic       Clock,
    input  logic       Reset_n,
    input  logic [1:0] RawButton,
    input  logic [1:0] RawSwitch,
    output logic [1:0] Button,
    output logic [1:0] Switch,
    output logic [1:0] Level
);

    typedef enum logic [1:0] {StIdle, StRiseWait, StHeld, StFallWait} chan_state_e;

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

    logic [3:0]                 sync1_q, sync2_q;
    logic [1:0]                 s_btn, s_sw;
    chan_state_e [1:0]          state_q, state_d;
    logic [1:0][CNT_W-1:0]      cnt_q, cnt_d;
    logic [1:0]                 stable_q, stable_d;
    logic [1:0]                 accept;
    logic                       pulse_q, pulse_d;
    logic [1:0]                 switch_q, switch_d;

    assign s_btn = sync2_q[3:2];
    assign s_sw  = sync2_q[1:0];

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            state_q  <= {StIdle, StIdle};
            cnt_q    <= '0;
            stable_q <= '0;
            pulse_q  <= 1'b0;
            switch_q <= '0;
        end else begin
            sync1_q  <= {RawButton, RawSwitch};
            sync2_q  <= sync1_q;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            pulse_q  <= pulse_d;
            switch_q <= switch_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        accept   = '0;
        for (int i = 0; i < 2; i++) begin
            case (state_q[i])
                StIdle: begin
                    if (s_btn[i]) begin
                        state_d[i] = StRiseWait;
                        cnt_d[i]   = CntOne;
                    end
                end
                StRiseWait: begin
                    if (!s_btn[i]) begin
                        state_d[i] = StIdle;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CntLast) begin
                        state_d[i]  = StHeld;
                        cnt_d[i]    = '0;
                        stable_d[i] = 1'b1;
                        accept[i]   = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CntOne;
                    end
                end
                StHeld: begin
                    if (!s_btn[i]) begin
                        state_d[i] = StFallWait;
                        cnt_d[i]   = CntOne;
                    end
                end
                StFallWait: begin
                    if (s_btn[i]) begin
                        state_d[i] = StHeld;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CntLast) begin
                        state_d[i]  = StIdle;
                        cnt_d[i]    = '0;
                        stable_d[i] = 1'b0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CntOne;
                    end
                end
                default: begin
                    state_d[i] = StIdle;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    // Reset button wins over execute, including when both are accepted on the same edge.
    always_comb begin
        pulse_d  = accept[0] & ~stable_q[1] & ~accept[1];
        switch_d = pulse_d ? s_sw : switch_q;
    end

    assign Level  = stable_q;
    assign Button = {stable_q[1], pulse_q};
    assign Switch = switch_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus random raw activity, checked every
// cycle against a run-length model of debouncing.
`timescale 1ns/1ps
module tb_button_conditioner;

    localparam int unsigned D = 4;

    logic       Clock   = 1'b0;
    logic       Reset_n = 1'b1;
    logic [1:0] RawButton = 2'b00;
    logic [1:0] RawSwitch = 2'b00;
    logic [1:0] Button, Switch, Level;

    int n_cmp = 0;
    int n_bad = 0;

    button_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
        .Clock     (Clock),
        .Reset_n   (Reset_n),
        .RawButton (RawButton),
        .RawSwitch (RawSwitch),
        .Button    (Button),
        .Switch    (Switch),
        .Level     (Level)
    );

    always #5 Clock = ~Clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: raw inputs reach the debouncer two edges late; a level flips once the
    // delayed input has disagreed with it on D consecutive edges.
    logic [1:0] m_b1 = '0, m_b2 = '0, m_s1 = '0, m_s2 = '0;
    logic [1:0] m_lvl = '0, m_lvl_nx;
    logic [1:0] m_sw = '0;
    logic       m_pulse = 1'b0, m_go;
    int         m_run [2] = '{0, 0};
    int         m_run_nx [2];

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            m_run_nx[i] = (m_b2[i] != m_lvl[i]) ? m_run[i] + 1 : 0;
            m_lvl_nx[i] = m_lvl[i];
            if (m_run_nx[i] >= int'(D)) begin
                m_lvl_nx[i] = ~m_lvl[i];
                m_run_nx[i] = 0;
            end
        end
        m_go = !m_lvl[0] && m_lvl_nx[0] && !m_lvl[1] && !m_lvl_nx[1];
    end

    always @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            m_b1 <= '0; m_b2 <= '0; m_s1 <= '0; m_s2 <= '0;
            m_lvl <= '0; m_sw <= '0; m_pulse <= 1'b0;
            m_run[0] <= 0; m_run[1] <= 0;
        end else begin
            m_b1 <= RawButton; m_b2 <= m_b1;
            m_s1 <= RawSwitch; m_s2 <= m_s1;
            m_lvl <= m_lvl_nx;
            m_run[0] <= m_run_nx[0]; m_run[1] <= m_run_nx[1];
            m_pulse <= m_go;
            if (m_go) m_sw <= m_s2;
        end
    end

    always @(negedge Clock) begin
        check_eq("model_level", 32'(Level), 32'(m_lvl));
        check_eq("model_button", 32'(Button), 32'({m_lvl[1], m_pulse}));
        check_eq("model_switch", 32'(Switch), 32'(m_sw));
    end

    // Observe n edges (sampling 1 time unit after each); k=0 is the first edge.
    task automatic watch(input int n, output int pulses, output int first_pulse,
                         output int rise0, output int fall0, output int rise1, output int fall1);
        logic [1:0] prev;
        prev = Level;
        pulses = 0; first_pulse = -1; rise0 = -1; fall0 = -1; rise1 = -1; fall1 = -1;
        for (int k = 0; k < n; k++) begin
            @(posedge Clock);
            #1;
            if (Button[0]) begin
                pulses++;
                if (first_pulse < 0) first_pulse = k;
            end
            if (!prev[0] && Level[0] && rise0 < 0) rise0 = k;
            if (prev[0] && !Level[0] && fall0 < 0) fall0 = k;
            if (!prev[1] && Level[1] && rise1 < 0) rise1 = k;
            if (prev[1] && !Level[1] && fall1 < 0) fall1 = k;
            prev = Level;
        end
    endtask

    initial begin
        int p, fp, r0, f0, r1, f1, acc;
        int pat [4] = '{1, 0, 1, 0};

        // Reset values with random raws
        #1 Reset_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            RawButton = 2'($urandom);
            RawSwitch = 2'($urandom);
            @(posedge Clock);
            #2;
            check_eq("rst_button", 32'(Button), 32'd0);
            check_eq("rst_switch", 32'(Switch), 32'd0);
            check_eq("rst_level", 32'(Level), 32'd0);
        end
        RawButton = 2'b00;
        RawSwitch = 2'b00;
        @(negedge Clock) Reset_n = 1'b1;
        watch(20, p, fp, r0, f0, r1, f1);
        check_eq("post_rst_pulses", 32'(p), 32'd0);
        check_eq("post_rst_outs", 32'({Button, Switch, Level}), 32'd0);

        // Clean press
        RawSwitch = 2'b11;
        RawButton[0] = 1'b1;
        watch(30, p, fp, r0, f0, r1, f1);
        check_eq("clean_pulses", 32'(p), 32'd1);
        check_eq("clean_pulse_edge", 32'(fp), 32'd5);
        check_eq("clean_level_edge", 32'(r0), 32'd5);
        check_eq("clean_switch", 32'(Switch), 32'd3);
        RawButton[0] = 1'b0;
        watch(20, p, fp, r0, f0, r1, f1);
        check_eq("release_pulses", 32'(p), 32'd0);
        check_eq("release_edge", 32'(f0), 32'd5);

        // Bounce rejection; switch moves 10 -> 01 mid-bounce
        RawSwitch = 2'b10;
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            RawButton[0] = pat[i][0];
            if (i == 1) RawSwitch = 2'b01;
            watch(3, p, fp, r0, f0, r1, f1);
            acc += p;
        end
        check_eq("bounce_early_pulses", 32'(acc), 32'd0);
        RawButton[0] = 1'b1;
        watch(12, p, fp, r0, f0, r1, f1);
        check_eq("bounce_pulses", 32'(p), 32'd1);
        check_eq("bounce_pulse_edge", 32'(fp), 32'd5);
        check_eq("bounce_switch", 32'(Switch), 32'd1);
        RawButton[0] = 1'b0;
        watch(20, p, fp, r0, f0, r1, f1);

        // Switch freeze
        RawSwitch = 2'b10;
        RawButton[0] = 1'b1;
        watch(12, p, fp, r0, f0, r1, f1);
        check_eq("freeze_pulses", 32'(p), 32'd1);
        check_eq("freeze_capture", 32'(Switch), 32'd2);
        RawSwitch = 2'b01;
        watch(50, p, fp, r0, f0, r1, f1);
        check_eq("freeze_no_pulse", 32'(p), 32'd0);
        check_eq("freeze_switch", 32'(Switch), 32'd2);
        RawButton[0] = 1'b0;
        watch(20, p, fp, r0, f0, r1, f1);

        // Reset-button priority
        RawButton[1] = 1'b1;
        watch(12, p, fp, r0, f0, r1, f1);
        check_eq("prio_l1_edge", 32'(r1), 32'd5);
        check_eq("prio_button1", 32'(Button[1]), 32'd1);
        RawSwitch = 2'b11;
        RawButton[0] = 1'b1;
        watch(20, p, fp, r0, f0, r1, f1);
        check_eq("prio_pulses", 32'(p), 32'd0);
        check_eq("prio_switch", 32'(Switch), 32'd2);
        check_eq("prio_level0", 32'(Level[0]), 32'd1);
        RawButton[1] = 1'b0;
        watch(20, p, fp, r0, f0, r1, f1);
        check_eq("prio_release_edge", 32'(f1), 32'd5);
        check_eq("prio_after_pulses", 32'(p), 32'd0);
        RawButton[0] = 1'b0;
        watch(20, p, fp, r0, f0, r1, f1);

        // Async reset two cycles into RISE_WAIT
        RawButton[0] = 1'b1;
        repeat (4) @(posedge Clock);
        #1 Reset_n = 1'b0;
        #1;
        check_eq("async_outs", 32'({Button, Switch, Level}), 32'd0);
        repeat (3) @(posedge Clock);
        @(negedge Clock) Reset_n = 1'b1;
        watch(20, p, fp, r0, f0, r1, f1);
        check_eq("async_pulses", 32'(p), 32'd1);
        check_eq("async_pulse_edge", 32'(fp), 32'd5);
        check_eq("async_switch", 32'(Switch), 32'd3);
        RawButton = 2'b00;
        watch(20, p, fp, r0, f0, r1, f1);

        // Random activity with occasional asynchronous resets
        for (int seg = 0; seg < 600; seg++) begin
            RawButton = 2'($urandom);
            RawSwitch = 2'($urandom);
            if ($urandom_range(0, 39) == 0) begin
                #2 Reset_n = 1'b0;
                repeat ($urandom_range(1, 2)) @(posedge Clock);
                @(negedge Clock) Reset_n = 1'b1;
            end
            repeat ($urandom_range(1, 9)) @(posedge Clock);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Front-end input conditioner placed directly upstream of the `SequentialCircuit` shift/load FSM. It synchronises and debounces the two raw push buttons and the two raw slide switches. It then drives the FSM's `Button[1:0]` and `Switch[1:0]` inputs:

- `Button[1]` is a clean, debounced reset level.
- `Button[0]` is a single-cycle execute pulse per physical press.
- `Switch` is a value frozen at the instant of each execute pulse, so the FSM never sees a mid-edit switch value.

## Interface

Parameters:

- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required to accept a level change. Legal minimum is 2. Default is 10 ms at 50 MHz; benches override it to 4.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES)`: width of each debounce counter. Derived; never overridden.

Ports:

- `Clock`, input, 1: single system clock, rising-edge active.
- `Reset_n`, input, 1: asynchronous, active-low reset.
- `RawButton`, input, 2: unsynchronised buttons. Bit 1 is reset request, bit 0 is execute.
- `RawSwitch`, input, 2: unsynchronised slide switches.
- `Button`, output, 2: bit 1 is debounced reset level; bit 0 is one-cycle execute pulse. Connects to the FSM `Button`.
- `Switch`, output, 2: switch value captured at the last execute pulse. Connects to the FSM `Switch`.
- `Level`, output, 2: debounced level of both buttons, for LEDs and debug.

## Operation

- **Synchroniser.** Every raw input (4 bits) passes through a two-flop synchroniser. The second-stage value is `s`.
- **Debounce channel.** Each button has one channel made of a state register, a `CNT_W` counter and a stable level. The channel states are:
  - `IDLE` (stable 0)
  - `RISE_WAIT`
  - `HELD` (stable 1)
  - `FALL_WAIT`
- **Transitions:**
  - `IDLE` → `RISE_WAIT` when `s`=1. The counter is loaded to 1.
  - `RISE_WAIT`: if `s`=0, return to `IDLE` with the counter cleared. Else, if counter = `DEBOUNCE_CYCLES`-1, go to `HELD` and set stable to 1. Else increment the counter.
  - `HELD` → `FALL_WAIT` when `s`=0. The counter is loaded to 1.
  - `FALL_WAIT` mirrors `RISE_WAIT`: return to `HELD` if `s`=1; go to `IDLE` and set stable to 0 once the counter reaches `DEBOUNCE_CYCLES`-1.
- **Glitch rejection.** Any glitch shorter than `DEBOUNCE_CYCLES` cycles of `s` produces no change on `Level` or `Button`.
- **Button outputs:**
  - `Level[i]` is the channel's stable level.
  - `Button[1]` equals `Level[1]`.
  - `Button[0]` is 1 for exactly the one cycle following the channel-0 `RISE_WAIT`→`HELD` transition.
- **No auto-repeat.** Holding execute produces exactly one pulse. Release produces no pulse.
- **Switch capture.** On the same edge that sets the execute pulse, `Switch` is loaded from the synchronised switches. Otherwise `Switch` holds its value. Switch bits themselves are not debounced; they are sampled only at the accept edge.
- **Reset priority.** While `Level[1]`=1, the execute pulse is suppressed and `Switch` is not loaded. Channel 0 still tracks its level, so a press accepted during reset produces no pulse, even after reset releases.
- **Simultaneous accept.** If channel 1 becomes `HELD` on the same edge that channel 0 would pulse, the pulse is suppressed.

## Timing

- **`Reset_n` = 0 (asynchronous):**
  - all synchroniser flops = 0
  - both channels in `IDLE`
  - counters = 0
  - `Button` = 2'b00, `Switch` = 2'b00, `Level` = 2'b00
- **Reset release.** Deassertion is consumed synchronously. A button held across reset release is seen as a fresh press, counted from zero.
- **Press latency.** Raw rises before edge E0 and stays high. `s` = 1 after E1. `RISE_WAIT` is entered at E2. `HELD`, `Level[0]`=1, `Button[0]`=1 and the `Switch` load all take effect at edge E(`DEBOUNCE_CYCLES`+1). `Button[0]` returns to 0 at the next edge.
- **Release latency.** Symmetric: `Level` falls at edge E(`DEBOUNCE_CYCLES`+1) after raw falls.
- **Minimum re-press interval.** About 2×`DEBOUNCE_CYCLES`+4 cycles, which covers the release debounce plus the press debounce.
- **`Reset_n` asserted mid-count.** The count is aborted immediately. No pulse is emitted. Outputs are 0 within the same cycle.
- **Counter overflow.** None: `RISE_WAIT`/`FALL_WAIT` exit at `DEBOUNCE_CYCLES`-1 and the counter does not run in `IDLE` or `HELD`.

## Test plan

All scenarios use `DEBOUNCE_CYCLES`=4.

- **Reset values.** Hold `Reset_n`=0 with raw inputs random. Expect `Button`=00, `Switch`=00, `Level`=00. Release with raws at 0; outputs must stay 00 for 20 cycles.
- **Clean press.** `RawSwitch`=2'b11, then `RawButton[0]`=1 sampled at E0 and held for 30 cycles. Expect `Button[0]`=1 only in the cycle after E5, with `Switch`=11 loaded at E5. Exactly one pulse; `Level[0]`=1 from E5.
- **Bounce rejection.** Toggle `RawButton[0]` 1,0,1,0 with each level held 3 cycles, then hold 1 for 10 cycles. Expect exactly one pulse, 6 edges after the final rise. Change `RawSwitch` 10→01 during the bounce; the value captured must be 01.
- **Switch freeze.** After a press captures `Switch`=10, change `RawSwitch` to 01 with no button press. `Switch` must stay 10 for 50 cycles.
- **Reset-button priority.** Hold `RawButton[1]`=1 until `Button[1]`=1, then press execute. Expect no `Button[0]` pulse and no change to `Switch`. Release both buttons; `Button[1]` falls 6 edges after raw falls.
- **Async reset mid-count.** Assert `Reset_n`=0 two cycles into `RISE_WAIT`. All outputs must be 0 before the next edge and no pulse may occur. Release with the button still held: exactly one pulse, 6 edges after the first post-reset edge.
